o2k_axi_responder: RTL

AXI4 slave (responder) terminating the oculink-to-kernel (o2k) master port of the oculink PCIe IP inside the kernel. Serves reads and writes issued by the NVMe device side into a local 128-bit-wide on-chip buffer. Typical traffic is completion-queue entries and DMA payload. Independent write and read engines share one simple dual-port RAM, all in the 250 MHz user clock domain.

---
 rtl/o2k_axi_responder_if.sv | 77 +++++++
 rtl/o2k_axi_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/o2k_axi_responder_if.sv
// AXI4 bus bundle between the oculink o2k master port and the kernel-side responder.
// One instance carries all five channels; the responder takes the slave modport.
interface o2k_axi_responder_if;
    logic [3:0]   o2k_awid;
    logic [63:0]  o2k_awaddr;
    logic [7:0]   o2k_awlen;
    logic [2:0]   o2k_awsize;
    logic [1:0]   o2k_awburst;
    logic         o2k_awlock;
    logic [3:0]   o2k_awcache;
    logic [2:0]   o2k_awprot;
    logic [3:0]   o2k_awqos;
    logic [3:0]   o2k_awregion;
    logic         o2k_awvalid;
    logic         o2k_awready;

    logic [127:0] o2k_wdata;
    logic [15:0]  o2k_wstrb;
    logic         o2k_wlast;
    logic         o2k_wvalid;
    logic         o2k_wready;

    logic [3:0]   o2k_bid;
    logic [1:0]   o2k_bresp;
    logic         o2k_bvalid;
    logic         o2k_bready;

    logic [3:0]   o2k_arid;
    logic [63:0]  o2k_araddr;
    logic [7:0]   o2k_arlen;
    logic [2:0]   o2k_arsize;
    logic [1:0]   o2k_arburst;
    logic         o2k_arlock;
    logic [3:0]   o2k_arcache;
    logic [2:0]   o2k_arprot;
    logic [3:0]   o2k_arqos;
    logic [3:0]   o2k_arregion;
    logic         o2k_arvalid;
    logic         o2k_arready;

    logic [3:0]   o2k_rid;
    logic [127:0] o2k_rdata;
    logic [1:0]   o2k_rresp;
    logic         o2k_rlast;
    logic         o2k_rvalid;
    logic         o2k_rready;

    modport slave (
        input  o2k_awid, o2k_awaddr, o2k_awlen, o2k_awsize, o2k_awburst,
               o2k_awlock, o2k_awcache, o2k_awprot, o2k_awqos, o2k_awregion, o2k_awvalid,
        output o2k_awready,
        input  o2k_wdata, o2k_wstrb, o2k_wlast, o2k_wvalid,
        output o2k_wready,
        output o2k_bid, o2k_bresp, o2k_bvalid,
        input  o2k_bready,
        input  o2k_arid, o2k_araddr, o2k_arlen, o2k_arsize, o2k_arburst,
               o2k_arlock, o2k_arcache, o2k_arprot, o2k_arqos, o2k_arregion, o2k_arvalid,
        output o2k_arready,
        output o2k_rid, o2k_rdata, o2k_rresp, o2k_rlast, o2k_rvalid,
        input  o2k_rready
    );

    modport master (
        output o2k_awid, o2k_awaddr, o2k_awlen, o2k_awsize, o2k_awburst,
               o2k_awlock, o2k_awcache, o2k_awprot, o2k_awqos, o2k_awregion, o2k_awvalid,
        input  o2k_awready,
        output o2k_wdata, o2k_wstrb, o2k_wlast, o2k_wvalid,
        input  o2k_wready,
        input  o2k_bid, o2k_bresp, o2k_bvalid,
        output o2k_bready,
        output o2k_arid, o2k_araddr, o2k_arlen, o2k_arsize, o2k_arburst,
               o2k_arlock, o2k_arcache, o2k_arprot, o2k_arqos, o2k_arregion, o2k_arvalid,
        input  o2k_arready,
        input  o2k_rid, o2k_rdata, o2k_rresp, o2k_rlast, o2k_rvalid,
        output o2k_rready
    );
endinterface

// File: rtl/o2k_axi_responder.sv
// AXI4 responder serving o2k reads/writes into a 128-bit on-chip buffer with independent engines.
// Define O2K_RESP_WSTRB_EN to honour wstrb byte lanes; otherwise every OKAY beat writes all 16 bytes.
module o2k_axi_responder #(
    parameter int unsigned MEM_AW    = 10,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input logic               clk,
    input logic               rst,
    o2k_axi_responder_if.slave bus
);
    localparam int unsigned WORDS       = 1 << MEM_AW;
    localparam logic [64:0] DEPTH       = 65'(1) << MEM_AW;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  BURST_INCR  = 2'b01;

    // Range failure outranks size/burst-type failure.
    function automatic logic [1:0] burst_status(input logic [63:0] addr, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
        logic [64:0] first_idx;
        logic [64:0] last_idx;
        first_idx = 65'((addr - BASE_ADDR) >> 4);
        last_idx  = (burst == BURST_INCR) ? first_idx + 65'(len) : first_idx;
        if (addr < BASE_ADDR || last_idx >= DEPTH)
            return RESP_DECERR;
        if (size != 3'b100 || (burst != BURST_INCR && burst != BURST_FIXED))
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [MEM_AW-1:0] word_index(input logic [63:0] addr);
        return MEM_AW'((addr - BASE_ADDR) >> 4);
    endfunction

    logic [127:0] mem [WORDS];

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    w_state_t          w_state, w_state_nxt;
    logic [3:0]        w_id;
    logic [MEM_AW-1:0] w_idx;
    logic [7:0]        w_len, w_cnt;
    logic              w_fixed, w_last_err;
    logic [1:0]        w_status, w_resp_final;
    logic              aw_hs, w_hs, b_hs, w_final, w_en;
    logic              awready_q, wready_q, bvalid_q;
    logic [3:0]        bid_q;
    logic [1:0]        bresp_q;

    r_state_t          r_state, r_state_nxt;
    logic [3:0]        r_id;
    logic [MEM_AW-1:0] r_idx;
    logic [7:0]        r_len, r_cnt;
    logic              r_fixed;
    logic [1:0]        r_status;
    logic              ar_hs, r_hs, r_final;
    logic              arready_q, rvalid_q, rlast_q;
    logic [3:0]        rid_q;
    logic [1:0]        rresp_q;
    logic [127:0]      rdata_q;

    assign bus.o2k_awready = awready_q;
    assign bus.o2k_wready  = wready_q;
    assign bus.o2k_bvalid  = bvalid_q;
    assign bus.o2k_bid     = bid_q;
    assign bus.o2k_bresp   = bresp_q;
    assign bus.o2k_arready = arready_q;
    assign bus.o2k_rvalid  = rvalid_q;
    assign bus.o2k_rid     = rid_q;
    assign bus.o2k_rresp   = rresp_q;
    assign bus.o2k_rlast   = rlast_q;
    assign bus.o2k_rdata   = rdata_q;

    logic unused_inputs;
    assign unused_inputs = ^{bus.o2k_awlock, bus.o2k_awcache, bus.o2k_awprot, bus.o2k_awqos,
                             bus.o2k_awregion, bus.o2k_arlock, bus.o2k_arcache, bus.o2k_arprot,
                             bus.o2k_arqos, bus.o2k_arregion, bus.o2k_wstrb};

    // ---------------- write engine ----------------
    assign aw_hs   = bus.o2k_awvalid && awready_q;
    assign w_hs    = bus.o2k_wvalid && wready_q;
    assign b_hs    = bvalid_q && bus.o2k_bready;
    assign w_final = (w_cnt == w_len);
    assign w_en    = w_hs && (w_status == RESP_OKAY);
    assign w_resp_final = (w_status != RESP_OKAY) ? w_status :
                          (w_last_err || !bus.o2k_wlast) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_final) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // A misplaced wlast only flags the response; the beat count alone ends the burst.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            w_id       <= bus.o2k_awid;
            w_idx      <= word_index(bus.o2k_awaddr);
            w_len      <= bus.o2k_awlen;
            w_fixed    <= (bus.o2k_awburst == BURST_FIXED);
            w_status   <= burst_status(bus.o2k_awaddr, bus.o2k_awlen, bus.o2k_awsize, bus.o2k_awburst);
            w_cnt      <= 8'd0;
            w_last_err <= 1'b0;
        end else if (w_hs) begin
            w_cnt      <= w_cnt + 8'd1;
            w_last_err <= w_last_err || (bus.o2k_wlast != w_final);
            if (!w_fixed) w_idx <= w_idx + MEM_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bresp_q   <= 2'b00;
        end else begin
            awready_q <= (w_state_nxt == W_IDLE);
            wready_q  <= (w_state_nxt == W_DATA);
            bvalid_q  <= (w_state_nxt == W_RESP);
            if (w_state == W_DATA && w_state_nxt == W_RESP) begin
                bid_q   <= w_id;
                bresp_q <= w_resp_final;
            end
        end
    end

`ifdef O2K_RESP_WSTRB_EN
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int i = 0; i < 16; i++)
                if (bus.o2k_wstrb[i]) mem[w_idx][8*i +: 8] <= bus.o2k_wdata[8*i +: 8];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (w_en) mem[w_idx] <= bus.o2k_wdata;
    end
`endif

    // ---------------- read engine ----------------
    assign ar_hs   = bus.o2k_arvalid && arready_q;
    assign r_hs    = rvalid_q && bus.o2k_rready;
    assign r_final = (r_cnt == r_len);

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_FETCH;
            R_FETCH: r_state_nxt = R_DATA;
            R_DATA:  if (r_hs) r_state_nxt = r_final ? R_IDLE : R_FETCH;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ar_hs) begin
            r_id     <= bus.o2k_arid;
            r_idx    <= word_index(bus.o2k_araddr);
            r_len    <= bus.o2k_arlen;
            r_fixed  <= (bus.o2k_arburst == BURST_FIXED);
            r_status <= burst_status(bus.o2k_araddr, bus.o2k_arlen, bus.o2k_arsize, bus.o2k_arburst);
            r_cnt    <= 8'd0;
        end else if (r_hs) begin
            r_cnt <= r_cnt + 8'd1;
            if (!r_fixed) r_idx <= r_idx + MEM_AW'(1);
        end
    end

    // The fetch register only loads in R_FETCH, so the beat stays put under backpressure;
    // a same-edge write lands after this read (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= 4'd0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
            rdata_q   <= 128'd0;
        end else begin
            arready_q <= (r_state_nxt == R_IDLE);
            rvalid_q  <= (r_state_nxt == R_DATA);
            if (r_state == R_FETCH) begin
                rid_q   <= r_id;
                rresp_q <= r_status;
                rlast_q <= r_final;
                rdata_q <= (r_status == RESP_OKAY) ? mem[r_idx] : 128'd0;
            end
        end
    end
endmodule
